alu_pipe: RTL and testbench
===========================

# alu_pipe

Two-stage pipelined, parametrised-width fixed-point ALU with valid/ready handshakes, saturating signed arithmetic, an internal MAC accumulator and sticky overflow reporting. It is the next-generation datapath ALU for the receiver core, sitting between the instruction decode/operand fetch stage and the register write-back stage. It supports back-pressure and chained multiply-accumulate without software holding partial sums.

## Interface
- `N`, 16: operand/result width, signed two's complement, ≥4.
- `O`, 8: opcode width.
- `S`, 5: shift-amount width.
- `FRAC`, N-1: fractional bits for MUL/MAC (Q1.(N-1) default).
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operation presented.
- `in_ready` out 1: operation accepted when `in_valid && in_ready`.
- `opcode` in O: operation select, encodings from the shared package.
- `a`, `b`, `c` in N each: signed operands (`c` is the MADD addend).
- `shift` in S: unsigned shift/rotate amount.
- `acc_clr` in 1: with MAC, treat the accumulator as 0 before the add.
- `out_valid` out 1: result available.
- `out_ready` in 1: downstream accepts when `out_valid && out_ready`.
- `out` out N: result.
- `sat` out 1: this result was clamped.
- `err` out 1: this result came from an unrecognised opcode.
- `sat_sticky` out 1: OR of every `sat` handed off since reset or the last `sticky_clr`.
- `sticky_clr` in 1: clear `sat_sticky`. Clear wins over a same-cycle set.

## Operation
- Arithmetic is done at 2N+2 bits signed. Saturation clamps to [-2^(N-1), 2^(N-1)-1] and sets `sat`.
- ADD: sat((a<<shift)+b). SUB: sat(b-(a<<shift)). The shift is arithmetic and performed at full width before the clamp.
- MUL: sat((a*b)>>>FRAC), truncating toward −inf.
- MADD: sat(((a*b)>>>FRAC)+c).
- MAC: acc ← sat((acc_clr?0:acc)+((a*b)>>>FRAC)). `out` = new acc.
- AND/OR/XOR: bitwise, never saturate.
- SHLA: a<<shift, with saturation. SHRA: a>>>shift. SHRL: a>>shift (logical).
- Shift amounts ≥N: SHLA gives 0 for a=0 and clamps otherwise; SHRA gives sign fill; SHRL gives 0.
- ROL/ROR: rotate `a` by shift mod N. These never saturate.
- NOP: `out`=0 and still produces a result beat.
- Unrecognised opcode: `out`=0, `err`=1, `sat`=0.
- Stage 1 (S1): registers opcode and operands, and computes the product and pre-shifted operand.
- Stage 2 (S2): does the add/clamp/select, updates acc, and drives the output registers.
- acc is updated only when a MAC enters S2. Consecutive MACs therefore chain without bubbles; S2 reads the acc value written by the previous MAC.
- `sat_sticky` sets on the output handshake of a beat with `sat`=1.

## Timing
- Latency is 2 cycles from an input handshake to `out_valid`, given no back-pressure. Throughput is 1 op/cycle.
- Handshake rules:
  - S2 advances when it is empty or `out_ready`=1.
  - S1 advances when it is empty or S2 advances.
  - `in_ready` = S1 empty or S1 advances (combinational from `out_ready`, no bubble).
- Under a stall, `out`, `sat` and `err` are held stable while `out_valid`=1.
- `out_valid` never drops without a handshake.
- At most 2 operations are in flight. None are lost or reordered.
- Reset (asynchronous, any time, including mid-pipeline) sets:
  - `out_valid`=0, `out`=0, `sat`=0, `err`=0;
  - `sat_sticky`=0, acc=0, both stage valids=0.
- `in_ready`=1 during reset release and the first cycle after.
- `acc_clr` is ignored for every opcode except MAC.

## Structure
- Shared package/definitions include:
  - opcode encodings (`ALU_NOP`…`ALU_ROR`, `ALU_MAC`, `ALU_MADD`);
  - saturation helper constants (MAX/MIN per N).
- Existing ALU opcode values are reused unchanged; MADD takes a new free code.
- One natural sub-module is `alu_sat`: a combinational clamp from 2N+2 bits to N bits with a flag, instanced in S2.

## Test plan
- ADD a=0x4000, b=0x0001, shift=1 → out=0x7FFF, sat=1, and `sat_sticky`=1 after the handshake. Then `sticky_clr` → `sat_sticky`=0.
- MUL 0x4000×0x4000 → 0x2000, sat=0. MUL 0x8000×0x8000 → 0x7FFF, sat=1.
- Four back-to-back MACs with a=b=0x4000 and `acc_clr` on the first → outputs 0x2000, 0x4000, 0x6000, 0x7FFF (last sat=1).
- ROL a=0x8001, shift=1 → 0x0003. ROR a=0x0001, shift=4 → 0x1000. SHRA a=0x8000, shift=20 → 0xFFFF. Opcode 0xFF → out=0, err=1.
- Issue 4 ops with `out_ready`=0 for 5 cycles → `in_ready` drops after 2 accepts. The outputs then drain in order with stable held values.
- Assert `rst_n`=0 with both stages full and acc=0x6000 → `out_valid`=0 immediately. After release, a MAC without `acc_clr` (a=b=0x4000) → 0x2000.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: opcode encodings and saturation bounds shared by the pipelined ALU.
package alu_pipe_pkg;
   typedef enum logic [7:0] {
      ALU_NOP  = 8'h00,
      ALU_ADD  = 8'h01,
      ALU_SUB  = 8'h02,
      ALU_MUL  = 8'h03,
      ALU_AND  = 8'h04,
      ALU_OR   = 8'h05,
      ALU_XOR  = 8'h06,
      ALU_SHLA = 8'h07,
      ALU_SHRA = 8'h08,
      ALU_SHRL = 8'h09,
      ALU_ROL  = 8'h0A,
      ALU_ROR  = 8'h0B,
      ALU_MAC  = 8'h0C,
      ALU_MADD = 8'h0D
   } alu_op_e;

   function automatic longint sat_max(input int n);
      return (64'sd1 <<< (n - 1)) - 64'sd1;
   endfunction

   function automatic longint sat_min(input int n);
      return -(64'sd1 <<< (n - 1));
   endfunction
endpackage

// File: rtl/alu_sat.sv
// alu_sat: clamps a 2N+2-bit signed value into N-bit signed range with an overflow flag.
module alu_sat import alu_pipe_pkg::*; #(
   parameter int N = 16
) (
   input  logic signed [2*N+1:0] d,
   output logic [N-1:0]          q,
   output logic                  ovf
);
   localparam logic signed [2*N+1:0] MAX = (2*N+2)'(sat_max(N));
   localparam logic signed [2*N+1:0] MIN = (2*N+2)'(sat_min(N));
   logic hi, lo;
   assign hi  = d > MAX;
   assign lo  = d < MIN;
   assign q   = hi ? MAX[N-1:0] : lo ? MIN[N-1:0] : d[N-1:0];
   assign ovf = hi || lo;
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage saturating fixed-point ALU with MAC accumulator and valid/ready flow control.
module alu_pipe import alu_pipe_pkg::*; #(
   parameter int N    = 16,
   parameter int O    = 8,
   parameter int S    = 5,
   parameter int FRAC = N - 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [O-1:0] opcode,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [N-1:0] c,
   input  logic [S-1:0] shift,
   input  logic         acc_clr,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out,
   output logic         sat,
   output logic         err,
   output logic         sat_sticky,
   input  logic         sticky_clr
);
   localparam int W = 2 * N + 2;
   logic                v1, adv1, adv2, clr1, sflag, rsat, rerr;
   logic [O-1:0]        op1;
   logic [N-1:0]        a1, b1, c1, acc, sres, res;
   logic [S-1:0]        sh1;
   logic signed [2*N-1:0] mult;
   logic signed [W-1:0] prod_c, shl_c, prod1, shl1, bw, cw, accw, wide;
   int unsigned         sa, r;
   assign adv2     = !out_valid || out_ready;
   assign adv1     = !v1 || adv2;
   assign in_ready = adv1;
   assign mult     = $signed(a) * $signed(b);
   assign prod_c   = $signed({{2{mult[2*N-1]}}, mult}) >>> FRAC;
   // beyond N+1 any nonzero a already clamps, so capping keeps the shift inside W bits
   assign sa       = 32'(shift);
   assign shl_c    = $signed({{(N+2){a[N-1]}}, a}) <<< (sa > N + 1 ? N + 1 : sa);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) v1 <= 1'b0;
      else if (adv1) v1 <= in_valid;
   always_ff @(posedge clk)
      if (in_valid && in_ready) begin
         op1   <= opcode;
         a1    <= a;
         b1    <= b;
         c1    <= c;
         sh1   <= shift;
         clr1  <= acc_clr;
         prod1 <= prod_c;
         shl1  <= shl_c;
      end
   assign bw   = $signed({{(N+2){b1[N-1]}}, b1});
   assign cw   = $signed({{(N+2){c1[N-1]}}, c1});
   assign accw = $signed({{(N+2){acc[N-1]}}, acc});
   assign r    = 32'(sh1) % N;
   assign wide = op1 == O'(ALU_ADD)  ? shl1 + bw :
                 op1 == O'(ALU_SUB)  ? bw - shl1 :
                 op1 == O'(ALU_MUL)  ? prod1 :
                 op1 == O'(ALU_MADD) ? prod1 + cw :
                 op1 == O'(ALU_MAC)  ? (clr1 ? prod1 : accw + prod1) : shl1;
   alu_sat #(.N(N)) u_sat (.d(wide), .q(sres), .ovf(sflag));
   always_comb begin
      res  = '0;
      rsat = 1'b0;
      rerr = 1'b0;
      case (op1)
         O'(ALU_NOP): ;
         O'(ALU_ADD), O'(ALU_SUB), O'(ALU_MUL), O'(ALU_MADD), O'(ALU_MAC), O'(ALU_SHLA): begin
            res  = sres;
            rsat = sflag;
         end
         O'(ALU_AND):  res = a1 & b1;
         O'(ALU_OR):   res = a1 | b1;
         O'(ALU_XOR):  res = a1 ^ b1;
         O'(ALU_SHRA): res = $signed(a1) >>> sh1;
         O'(ALU_SHRL): res = a1 >> sh1;
         O'(ALU_ROL):  res = (a1 << r) | (a1 >> (N - r));
         O'(ALU_ROR):  res = (a1 >> r) | (a1 << (N - r));
         default:      rerr = 1'b1;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out        <= '0;
         sat        <= 1'b0;
         err        <= 1'b0;
         acc        <= '0;
         sat_sticky <= 1'b0;
      end else begin
         sat_sticky <= !sticky_clr && (sat_sticky || (out_valid && out_ready && sat));
         if (adv2) begin
            out_valid <= v1;
            if (v1) begin
               out <= res;
               sat <= rsat;
               err <= rerr;
               if (op1 == O'(ALU_MAC)) acc <= sres;
            end
         end
      end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe with hand-computed expectations.
module tb_alu_pipe;
   import alu_pipe_pkg::*;
   logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, acc_clr = 1'b0, out_ready = 1'b1, sticky_clr = 1'b0;
   logic        in_ready, out_valid, sat, err, sat_sticky;
   logic [7:0]  opcode = 8'h00;
   logic [15:0] a = '0, b = '0, c = '0, out;
   logic [4:0]  shift = '0;
   int          checks = 0, failures = 0;

   always #5 clk = ~clk;

   alu_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
      .a(a), .b(b), .c(c), .shift(shift), .acc_clr(acc_clr), .out_valid(out_valid),
      .out_ready(out_ready), .out(out), .sat(sat), .err(err), .sat_sticky(sat_sticky),
      .sticky_clr(sticky_clr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [7:0] op, input logic [15:0] av, bv, cv,
                         input logic [4:0] sh, input logic clr, input logic [15:0] eo,
                         input logic es, input logic ee);
      opcode = op; a = av; b = bv; c = cv; shift = sh; acc_clr = clr; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; acc_clr = 1'b0;
      @(posedge clk); #1;
      chk({tag, " valid"}, out_valid, 1);
      chk({tag, " out"}, out, eo);
      chk({tag, " sat"}, sat, es);
      chk({tag, " err"}, err, ee);
   endtask

   logic [15:0] q[$];
   logic [15:0] mexp[4] = '{16'h2000, 16'h4000, 16'h6000, 16'h7FFF};
   int          acc_n = 0, nxt = 1;
   logic        hin, hout;

   initial begin
      @(posedge clk); #1;
      chk("rst out_valid", out_valid, 0);
      chk("rst out", out, 0);
      chk("rst sat", sat, 0);
      chk("rst err", err, 0);
      chk("rst sticky", sat_sticky, 0);
      chk("rst in_ready", in_ready, 1);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post-rst in_ready", in_ready, 1);

      run_op("add sat", ALU_ADD, 16'h4000, 16'h0001, 0, 5'd1, 0, 16'h7FFF, 1, 0);
      @(posedge clk); #1;
      chk("sticky set", sat_sticky, 1);
      sticky_clr = 1'b1;
      @(posedge clk); #1;
      sticky_clr = 1'b0;
      chk("sticky clr", sat_sticky, 0);

      run_op("mul half", ALU_MUL, 16'h4000, 16'h4000, 0, 0, 0, 16'h2000, 0, 0);
      run_op("mul minmin", ALU_MUL, 16'h8000, 16'h8000, 0, 0, 0, 16'h7FFF, 1, 0);
      sticky_clr = 1'b1;
      @(posedge clk); #1;
      sticky_clr = 1'b0;
      chk("clr beats set", sat_sticky, 0);

      run_op("mul neg", ALU_MUL, 16'hC000, 16'h4000, 0, 0, 0, 16'hE000, 0, 0);
      run_op("mul floor", ALU_MUL, 16'hFFFF, 16'h0001, 0, 0, 0, 16'hFFFF, 0, 0);
      run_op("sub", ALU_SUB, 16'h0010, 16'h0100, 0, 5'd2, 0, 16'h00C0, 0, 0);
      run_op("madd", ALU_MADD, 16'h4000, 16'h4000, 16'h1000, 0, 0, 16'h3000, 0, 0);
      run_op("add clr ign", ALU_ADD, 16'h0002, 16'h0003, 0, 0, 1, 16'h0005, 0, 0);
      run_op("xor", ALU_XOR, 16'hF0F0, 16'h0FF0, 0, 0, 0, 16'hFF00, 0, 0);
      run_op("rol", ALU_ROL, 16'h8001, 0, 0, 5'd1, 0, 16'h0003, 0, 0);
      run_op("ror", ALU_ROR, 16'h0001, 0, 0, 5'd4, 0, 16'h1000, 0, 0);
      run_op("shra big", ALU_SHRA, 16'h8000, 0, 0, 5'd20, 0, 16'hFFFF, 0, 0);
      run_op("shrl big", ALU_SHRL, 16'h8000, 0, 0, 5'd20, 0, 16'h0000, 0, 0);
      run_op("shla big", ALU_SHLA, 16'h0001, 0, 0, 5'd20, 0, 16'h7FFF, 1, 0);
      run_op("shla zero", ALU_SHLA, 16'h0000, 0, 0, 5'd20, 0, 16'h0000, 0, 0);
      run_op("nop", ALU_NOP, 16'h1234, 16'h5678, 0, 0, 0, 16'h0000, 0, 0);
      run_op("bad op", 8'hFF, 16'h1234, 16'h5678, 0, 0, 0, 16'h0000, 0, 1);

      for (int i = 0; i < 5; i++) begin
         in_valid = i < 4; opcode = ALU_MAC; a = 16'h4000; b = 16'h4000; shift = 0; acc_clr = i == 0;
         @(posedge clk); #1;
         if (i >= 1) begin
            chk("mac valid", out_valid, 1);
            chk("mac out", out, mexp[i-1]);
            chk("mac sat", sat, i == 4);
         end
      end
      in_valid = 1'b0; acc_clr = 1'b0;
      @(posedge clk); #1;

      opcode = ALU_ADD; b = 0; shift = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         out_ready = cyc >= 5;
         in_valid = nxt <= 4;
         a = 16'(nxt);
         #1;
         hin = in_valid && in_ready;
         hout = out_valid && out_ready;
         if (cyc == 2) begin
            chk("stall in_ready", in_ready, 0);
            chk("stall accepts", acc_n, 2);
         end
         if (cyc >= 2 && cyc <= 4) begin
            chk("stall held valid", out_valid, 1);
            chk("stall held out", out, 16'd1);
         end
         if (hout) chk("drain order", out, q.size() > 0 ? q.pop_front() : 16'hDEAD);
         @(posedge clk); #1;
         if (hin) begin
            q.push_back(a);
            acc_n++;
            nxt++;
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      chk("drain empty", q.size(), 0);
      chk("drain count", acc_n, 4);

      run_op("mac1", ALU_MAC, 16'h4000, 16'h4000, 0, 0, 1, 16'h2000, 0, 0);
      run_op("mac2", ALU_MAC, 16'h4000, 16'h4000, 0, 0, 0, 16'h4000, 0, 0);
      run_op("mac3", ALU_MAC, 16'h4000, 16'h4000, 0, 0, 0, 16'h6000, 0, 0);
      out_ready = 1'b0; opcode = ALU_XOR; a = 16'h0001; b = 16'h0002; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("full in_ready", in_ready, 0);
      chk("sticky before rst", sat_sticky, 1);
      rst_n = 1'b0;
      #1;
      chk("async rst valid", out_valid, 0);
      chk("async rst out", out, 0);
      chk("async rst sticky", sat_sticky, 0);
      chk("async rst in_ready", in_ready, 1);
      #3 rst_n = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      run_op("mac after rst", ALU_MAC, 16'h4000, 16'h4000, 0, 0, 0, 16'h2000, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
